// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: single-clock TX FIFO controller in front of an external dp_ram
// (both RAM clocks tied to i_clk). Owns the write/read pointers, full/count and
// a 2-entry first-word-fall-through buffer that hides the RAM's registered read.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both
// high. Write side: i_wvalid/o_wready. Read side: o_rvalid/i_rready. A source
// holds its data stable while valid is high and ready is low.
//
// Optional feature: define TX_FIFO_CTRL_ERR_EN to build the sticky overflow
// flag o_ovf. Without it o_ovf is tied to 0.
module tx_fifo_ctrl #(
    parameter int RAM_DEPTH  = 1024,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_wvalid,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_wready,
    output logic                  o_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_rready,
    output logic [ADDR_WIDTH+1:0] o_count,
    output logic [ADDR_WIDTH-1:0] o_ram_waddr,
    output logic                  o_ram_wen,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    output logic [ADDR_WIDTH-1:0] o_ram_raddr,
    output logic                  o_ram_ren,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic                  o_ovf
);

    // Output buffer occupancy; the encoding equals the number of held words.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  inflight_q, inflight_d;
    buf_state_e            buf_q, buf_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    logic [ADDR_WIDTH:0]   ram_occ;
    logic                  full;
    logic                  accept;
    logic                  pop;
    logic                  fetch;
    logic [1:0]            buf_cnt;
    logic [1:0]            cnt_after_pop;
    logic [1:0]            level_next;

    // RAM occupancy uses registered pointers only, so a word becomes fetchable
    // the cycle after its write and a same-address read never sees stale data.
    assign ram_occ  = wptr_q - rptr_q;
    assign full     = (ram_occ == (ADDR_WIDTH+1)'(RAM_DEPTH));
    assign buf_cnt  = buf_q;

    assign o_wready = !full;
    assign o_rvalid = (buf_q != BUF_EMPTY);
    assign o_rdata  = head_q;

    assign accept = i_wvalid && !full && !i_flush;
    assign pop    = o_rvalid && i_rready;

    // Words the buffer will hold after this edge: current + arriving - leaving.
    // Fetch keeps buffer plus in-flight at two or fewer.
    assign cnt_after_pop = buf_cnt - {1'b0, pop};
    assign level_next    = cnt_after_pop + {1'b0, inflight_q};
    assign fetch         = (ram_occ != '0) && (level_next < 2'd2) && !i_flush;

    assign o_ram_wen   = accept;
    assign o_ram_waddr = wptr_q[ADDR_WIDTH-1:0];
    assign o_ram_wdata = i_wdata;
    assign o_ram_ren   = fetch;
    assign o_ram_raddr = rptr_q[ADDR_WIDTH-1:0];

    assign o_count = (ADDR_WIDTH+2)'(ram_occ)
                   + (ADDR_WIDTH+2)'(inflight_q)
                   + (ADDR_WIDTH+2)'(buf_cnt);

    // Next-state for pointers, in-flight marker and the FWFT buffer; flush wins.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = fetch;
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (fetch) begin
            rptr_d = rptr_q + 1'b1;
        end

        // Shift entry 1 to the head when the head leaves with two held.
        if (pop && (buf_q == BUF_TWO)) begin
            head_d = tail_q;
        end
        // Returning RAM word lands in the first free slot after the shift.
        if (inflight_q) begin
            if (cnt_after_pop == 2'd0) begin
                head_d = i_ram_rdata;
            end else begin
                tail_d = i_ram_rdata;
            end
        end

        unique case (level_next)
            2'd0:    buf_d = BUF_EMPTY;
            2'd1:    buf_d = BUF_ONE;
            default: buf_d = BUF_TWO;
        endcase

        if (i_flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
            buf_d      = BUF_EMPTY;
            head_d     = '0;
        end
    end

    // State registers: pointers, in-flight marker and buffer state machine.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            buf_q      <= BUF_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef TX_FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a write offered while full is dropped and flagged.
    always_comb begin
        ovf_d = ovf_q;
        if (i_flush) begin
            ovf_d = 1'b0;
        end else if (i_wvalid && full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register, cleared by reset or flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Bench for tx_fifo_ctrl. Models the dp_ram (registered read, old data on a
// same-address read during write), drives both handshakes from tasks and
// checks every popped word and the word count against an expected queue.
module tb_tx_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

`ifdef TX_FIFO_CTRL_ERR_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          flush;
  logic          wvalid;
  logic [DW-1:0] wdata;
  logic          o_wready;
  logic          o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          rready;
  logic [AW+1:0] o_count;
  logic [AW-1:0] ram_waddr;
  logic          ram_wen;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic          ram_ren;
  logic [DW-1:0] ram_rdata;
  logic          o_ovf;

  tx_fifo_ctrl #(
    .RAM_DEPTH (DEPTH),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (flush),
    .i_wvalid   (wvalid),
    .i_wdata    (wdata),
    .o_wready   (o_wready),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .i_rready   (rready),
    .o_count    (o_count),
    .o_ram_waddr(ram_waddr),
    .o_ram_wen  (ram_wen),
    .o_ram_wdata(ram_wdata),
    .o_ram_raddr(ram_raddr),
    .o_ram_ren  (ram_ren),
    .i_ram_rdata(ram_rdata),
    .o_ovf      (o_ovf)
  );

  // dp_ram model: registered read returns the pre-write contents on collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic          wr_pend;
  int            n_checks;
  int            n_errors;
  int            n_pops;
  int            n_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle of stimulus, applied just after the rising edge. A write is
  // predicted accepted when offered while o_wready is high and not flushing.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    @(posedge clk);
    #1;
    wvalid  = wv;
    wdata   = wd;
    rready  = rr;
    flush   = fl;
    wr_pend = wv && o_wready && !fl && rst_n;
    if (wr_pend) begin
      exp_q.push_back(wd);
      n_wr++;
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      c++;
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_count", 32'(o_count), 32'(0));
  endtask

  // ---------------- monitor ----------------
  // Count must equal words accepted minus words popped; every pop must match
  // the oldest expected word. A flush empties the expected queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n) begin
      chk("count", 32'(o_count), 32'(exp_q.size() - int'(wr_pend)));
      if (flush) begin
        exp_q.delete();
      end else if (o_rvalid && rready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(o_rdata), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 32'(o_rdata), 32'(e));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int p0;
    int w0;
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    n_wr     = 0;
    wr_pend  = 1'b0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wvalid   = 1'b0;
    wdata    = '0;
    rready   = 1'b0;

    // Reset values
    #12;
    chk("rst_count", 32'(o_count), 32'(0));
    chk("rst_rvalid", 32'(o_rvalid), 32'(0));
    chk("rst_wready", 32'(o_wready), 32'(1));
    chk("rst_rdata", 32'(o_rdata), 32'(0));
    chk("rst_ovf", 32'(o_ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single word: written at edge N, visible after edge N+2
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("lat_n_rvalid", 32'(o_rvalid), 32'(0));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("lat_n1_rvalid", 32'(o_rvalid), 32'(0));
    chk("lat_n1_count", 32'(o_count), 32'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("lat_n2_rvalid", 32'(o_rvalid), 32'(1));
    chk("lat_n2_rdata", 32'(o_rdata), 32'hA5);
    chk("lat_n2_count", 32'(o_count), 32'(1));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("single_pop_count", 32'(o_count), 32'(0));
    chk("single_pop_rvalid", 32'(o_rvalid), 32'(0));

    // Full: DEPTH + 2 words fit, then o_wready drops
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("full_wready_high", 32'(o_wready), 32'(1));
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("full_wready_low", 32'(o_wready), 32'(0));
    chk("full_count", 32'(o_count), 32'(DEPTH + 2));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("full_ovf", 32'(o_ovf), 32'(EXP_OVF));
    chk("full_count_after_drop", 32'(o_count), 32'(DEPTH + 2));
    drain(3000);

    // Flush with one word buffered, one in flight and one in RAM, plus a write
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    chk("pre_flush_count", 32'(o_count), 32'(3));
    chk("pre_flush_rvalid", 32'(o_rvalid), 32'(1));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", 32'(o_count), 32'(0));
    chk("flush_rvalid", 32'(o_rvalid), 32'(0));
    chk("flush_ovf", 32'(o_ovf), 32'(0));
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_rvalid_early", 32'(o_rvalid), 32'(0));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("post_flush_rvalid", 32'(o_rvalid), 32'(1));
    chk("post_flush_rdata", 32'(o_rdata), 32'h3C);
    drain(20);

    // Streaming across pointer wrap: one pop per cycle after 3-cycle latency
    p0 = n_pops;
    w0 = n_wr;
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_writes", 32'(n_wr - w0), 32'(3000));
    chk("stream_pops", 32'(n_pops - p0), 32'(2997));
    drain(20);

    // Backpressure: continuous writer, random reader
    d = 8'($urandom);
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1, d, 1'($urandom_range(0, 1)), 1'b0);
      if (wr_pend) d = 8'($urandom);
    end
    drain(3000);

    // Reset mid-stream with five words held and a write pending
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(o_count), 32'(5));
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(o_count), 32'(0));
    chk("midrst_rvalid", 32'(o_rvalid), 32'(0));
    chk("midrst_wready", 32'(o_wready), 32'(1));
    chk("midrst_rdata", 32'(o_rdata), 32'(0));
    exp_q.delete();
    wr_pend = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
